// File: rtl/iobus_bridge.sv
// CPU-to-I/O-port bridge: splits multi-byte IN/OUT accesses into device-sized
// bus cycles, with stall handling and a floating-bus timeout.
module iobus_bridge #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned MAX_BYTES = 4,
  parameter int unsigned LEN_W     = 3,
  parameter int unsigned READ_LAT  = 1,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_read_do,
  input  logic [ADDR_W-1:0]      cpu_read_address,
  input  logic [LEN_W-1:0]       cpu_read_length,
  output logic [8*MAX_BYTES-1:0] cpu_read_data,
  output logic                   cpu_read_done,
  input  logic                   cpu_write_do,
  input  logic [ADDR_W-1:0]      cpu_write_address,
  input  logic [LEN_W-1:0]       cpu_write_length,
  input  logic [8*MAX_BYTES-1:0] cpu_write_data,
  output logic                   cpu_write_done,
  output logic                   busy,
  output logic [ADDR_W-1:0]      bus_address,
  output logic                   bus_read,
  output logic                   bus_write,
  output logic [LEN_W-1:0]       bus_datasize,
  output logic [8*MAX_BYTES-1:0] bus_writedata,
  input  logic [1:0]             bus_width,
  input  logic                   bus_wait,
  input  logic [8*MAX_BYTES-1:0] bus_readdata,
  output logic                   bus_timeout
);

  localparam int unsigned DATA_W = 8 * MAX_BYTES;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_CHECK} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [LEN_W-1:0]    off_q, off_d;
  logic [LEN_W-1:0]    k_q, k_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                is_wr_q, is_wr_d;
  logic                rd_stb_q, rd_stb_d;
  logic                wr_stb_q, wr_stb_d;
  logic                rd_done_q, rd_done_d;
  logic                wr_done_q, wr_done_d;
  logic                tmo_q, tmo_d;
  logic                busy_q, busy_d;

  logic [LEN_W-1:0]    req_len;
  logic [LEN_W-1:0]    chunk;
  logic                leave_ok;
  logic                abandon;
  logic [31:0]         wbytes;
  logic [31:0]         kk;

  // Chunk size: bounded by bytes remaining, device width and data-port width
  always_comb begin
    case (bus_width)
      2'd0:    wbytes = 32'd1;
      2'd1:    wbytes = 32'd2;
      default: wbytes = 32'd4;
    endcase
    kk = 32'(rem_q);
    if (wbytes < kk) kk = wbytes;
    if (MAX_BYTES < kk) kk = MAX_BYTES;
    chunk = LEN_W'(kk);
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    off_d     = off_q;
    k_d       = k_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    is_wr_d   = is_wr_q;
    rd_stb_d  = 1'b0;
    wr_stb_d  = 1'b0;
    rd_done_d = 1'b0;
    wr_done_d = 1'b0;
    tmo_d     = 1'b0;
    req_len   = cpu_write_do ? cpu_write_length : cpu_read_length;
    leave_ok  = !bus_wait && (is_wr_q || (cnt_q >= CNT_W'(READ_LAT)));
    abandon   = !leave_ok && (cnt_q >= CNT_W'(TIMEOUT));

    case (state_q)
      S_IDLE: begin
        if (cpu_write_do || cpu_read_do) begin
          is_wr_d = cpu_write_do;
          addr_d  = cpu_write_do ? cpu_write_address : cpu_read_address;
          rem_d   = (req_len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : req_len;
          wdata_d = cpu_write_do ? cpu_write_data : '0;
          off_d   = '0;
          if (req_len == '0) begin
            wr_done_d = cpu_write_do;
            rd_done_d = !cpu_write_do;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        k_d      = chunk;
        cnt_d    = '0;
        rd_stb_d = !is_wr_q;
        wr_stb_d = is_wr_q;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (leave_ok || abandon) begin
          // Bytes of an abandoned read float high
          if (!is_wr_q) begin
            for (int unsigned i = 0; i < MAX_BYTES; i++) begin
              if ((i >= 32'(off_q)) && (i < 32'(off_q) + 32'(k_q))) begin
                rdata_d[8*i +: 8] = abandon ? 8'hFF : bus_readdata[8*(i - 32'(off_q)) +: 8];
              end
            end
          end
          tmo_d   = abandon;
          addr_d  = addr_q + ADDR_W'(k_q);
          off_d   = off_q + k_q;
          rem_d   = rem_q - k_q;
          wdata_d = wdata_q >> {k_q, 3'b000};
          if (rem_q == k_q) begin
            wr_done_d = is_wr_q;
            rd_done_d = !is_wr_q;
          end
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        state_d = (rem_q == '0) ? S_IDLE : S_ISSUE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      off_q     <= '0;
      k_q       <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      is_wr_q   <= 1'b0;
      rd_stb_q  <= 1'b0;
      wr_stb_q  <= 1'b0;
      rd_done_q <= 1'b0;
      wr_done_q <= 1'b0;
      tmo_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      off_q     <= off_d;
      k_q       <= k_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      is_wr_q   <= is_wr_d;
      rd_stb_q  <= rd_stb_d;
      wr_stb_q  <= wr_stb_d;
      rd_done_q <= rd_done_d;
      wr_done_q <= wr_done_d;
      tmo_q     <= tmo_d;
      busy_q    <= busy_d;
    end
  end

  assign cpu_read_data  = rdata_q;
  assign cpu_read_done  = rd_done_q;
  assign cpu_write_done = wr_done_q;
  assign busy           = busy_q;
  assign bus_address    = addr_q;
  assign bus_read       = rd_stb_q;
  assign bus_write      = wr_stb_q;
  assign bus_datasize   = rem_q;
  assign bus_writedata  = wdata_q;
  assign bus_timeout    = tmo_q;

endmodule

// File: tb/tb_iobus_bridge.sv
// Directed bench for iobus_bridge: chunking per device width, stalls,
// timeout, reset abort and address wrap.
module tb_iobus_bridge;

  logic        clk;
  logic        reset;
  logic        cpu_read_do;
  logic [15:0] cpu_read_address;
  logic [2:0]  cpu_read_length;
  logic [31:0] cpu_read_data;
  logic        cpu_read_done;
  logic        cpu_write_do;
  logic [15:0] cpu_write_address;
  logic [2:0]  cpu_write_length;
  logic [31:0] cpu_write_data;
  logic        cpu_write_done;
  logic        busy;
  logic [15:0] bus_address;
  logic        bus_read;
  logic        bus_write;
  logic [2:0]  bus_datasize;
  logic [31:0] bus_writedata;
  logic [1:0]  bus_width;
  logic        bus_wait;
  logic [31:0] bus_readdata;
  logic        bus_timeout;

  iobus_bridge #(.ADDR_W(16), .MAX_BYTES(4), .LEN_W(3), .READ_LAT(1), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .cpu_read_do(cpu_read_do), .cpu_read_address(cpu_read_address),
    .cpu_read_length(cpu_read_length), .cpu_read_data(cpu_read_data),
    .cpu_read_done(cpu_read_done),
    .cpu_write_do(cpu_write_do), .cpu_write_address(cpu_write_address),
    .cpu_write_length(cpu_write_length), .cpu_write_data(cpu_write_data),
    .cpu_write_done(cpu_write_done), .busy(busy),
    .bus_address(bus_address), .bus_read(bus_read), .bus_write(bus_write),
    .bus_datasize(bus_datasize), .bus_writedata(bus_writedata),
    .bus_width(bus_width), .bus_wait(bus_wait), .bus_readdata(bus_readdata),
    .bus_timeout(bus_timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Device model state
  logic [31:0] rd_table [8];
  int          rd_strobes = 0;
  int          rd_base    = 0;
  int          wait_until = 0;
  logic        wait_all   = 1'b0;
  int          rd_idx;

  // Observation log
  logic [15:0] st_addr[$];
  logic [2:0]  st_size[$];
  logic [31:0] st_wdata[$];
  logic        st_wr[$];
  int          st_cyc[$];
  int          rd_done_cnt = 0, wr_done_cnt = 0, to_cnt = 0;
  int          rd_done_last = -1, wr_done_last = -1, to_last = -1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign bus_wait = wait_all || (cyc < wait_until);

  always_comb begin
    rd_idx = rd_strobes - rd_base - 1;
    if (rd_idx >= 0 && rd_idx < 8) bus_readdata = rd_table[rd_idx];
    else                           bus_readdata = 32'h0;
  end

  always @(negedge clk) begin
    if (bus_read || bus_write) begin
      st_addr.push_back(bus_address);
      st_size.push_back(bus_datasize);
      st_wdata.push_back(bus_writedata);
      st_wr.push_back(bus_write);
      st_cyc.push_back(cyc);
    end
    if (bus_read) rd_strobes <= rd_strobes + 1;
    if (cpu_read_done) begin rd_done_cnt <= rd_done_cnt + 1; rd_done_last <= cyc; end
    if (cpu_write_done) begin wr_done_cnt <= wr_done_cnt + 1; wr_done_last <= cyc; end
    if (bus_timeout) begin to_cnt <= to_cnt + 1; to_last <= cyc; end
  end

  task automatic issue(input logic wr, input logic rd, input logic [15:0] addr,
                       input logic [2:0] len, input logic [31:0] data, output int t);
    t = cyc;
    cpu_write_do      = wr;
    cpu_read_do       = rd;
    cpu_write_address = addr;
    cpu_read_address  = addr + 16'h10;
    if (!wr) cpu_read_address = addr;
    cpu_write_length  = len;
    cpu_read_length   = len;
    cpu_write_data    = data;
    @(negedge clk);
    cpu_write_do = 1'b0;
    cpu_read_do  = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if ({bus_read, bus_write, cpu_read_done, cpu_write_done, bus_timeout} !== 5'b0) begin
      n_fail++; $display("FAIL reset_pulses: got %b want 00000", {bus_read, bus_write, cpu_read_done, cpu_write_done, bus_timeout}); end
    n_checks++; if (bus_address !== 16'h0 || bus_datasize !== 3'd0) begin
      n_fail++; $display("FAIL reset_addr_size: got %h/%0d want 0/0", bus_address, bus_datasize); end
    n_checks++; if (bus_writedata !== 32'h0 || cpu_read_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: got %h/%h want 0/0", bus_writedata, cpu_read_data); end
    reset = 1'b0;
    settle(1);
  endtask

  task automatic test_byte_read;
    int t, s0, rd0, wr0;
    bus_width = 2'd0;
    rd_table[0] = 32'hA5A5A511; rd_table[1] = 32'hA5A5A522;
    rd_table[2] = 32'hA5A5A533; rd_table[3] = 32'hA5A5A544;
    rd_base = rd_strobes; s0 = st_addr.size(); rd0 = rd_done_cnt; wr0 = wr_done_cnt;
    issue(1'b0, 1'b1, 16'h03F8, 3'd4, 32'h0, t);
    settle(30);
    n_checks++; if (st_addr.size() - s0 !== 4) begin n_fail++; $display("FAIL byte_read_strobes: got %0d want 4", st_addr.size() - s0); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++; if (st_addr[s0+i] !== 16'h03F8 + 16'(i) || st_size[s0+i] !== 3'(4 - i) || st_wr[s0+i] !== 1'b0) begin
          n_fail++; $display("FAIL byte_read_chunk%0d: got %h/%0d/%b want %h/%0d/0", i, st_addr[s0+i], st_size[s0+i], st_wr[s0+i], 16'h03F8 + 16'(i), 4 - i); end
        n_checks++; if (st_cyc[s0+i] !== t + 2 + 4*i) begin
          n_fail++; $display("FAIL byte_read_strobe_cyc%0d: got %0d want %0d", i, st_cyc[s0+i] - t, 2 + 4*i); end
      end
    end
    n_checks++; if (cpu_read_data !== 32'h44332211) begin n_fail++; $display("FAIL byte_read_data: got %h want 44332211", cpu_read_data); end
    n_checks++; if (rd_done_cnt - rd0 !== 1 || wr_done_cnt - wr0 !== 0) begin
      n_fail++; $display("FAIL byte_read_done_count: got rd %0d wr %0d want 1/0", rd_done_cnt - rd0, wr_done_cnt - wr0); end
    n_checks++; if (rd_done_last - t !== 16) begin n_fail++; $display("FAIL byte_read_done_cyc: got T+%0d want T+16", rd_done_last - t); end
  endtask

  task automatic test_word_write;
    int t, s0, wr0;
    bus_width = 2'd2;
    s0 = st_addr.size(); wr0 = wr_done_cnt;
    issue(1'b1, 1'b0, 16'h0080, 3'd4, 32'hDEADBEEF, t);
    settle(12);
    n_checks++; if (st_addr.size() - s0 !== 1) begin n_fail++; $display("FAIL word_write_strobes: got %0d want 1", st_addr.size() - s0); end
    else begin
      n_checks++; if (st_wr[s0] !== 1'b1 || st_wdata[s0] !== 32'hDEADBEEF || st_size[s0] !== 3'd4 || st_addr[s0] !== 16'h0080) begin
        n_fail++; $display("FAIL word_write_cycle: got wr %b %h size %0d addr %h want 1 DEADBEEF 4 0080", st_wr[s0], st_wdata[s0], st_size[s0], st_addr[s0]); end
      n_checks++; if (st_cyc[s0] - t !== 2) begin n_fail++; $display("FAIL word_write_strobe_cyc: got T+%0d want T+2", st_cyc[s0] - t); end
    end
    n_checks++; if (wr_done_cnt - wr0 !== 1 || wr_done_last - t !== 3) begin
      n_fail++; $display("FAIL word_write_done: got %0d pulses at T+%0d want 1 at T+3", wr_done_cnt - wr0, wr_done_last - t); end
  endtask

  task automatic test_half_write;
    int t, s0;
    bus_width = 2'd1;
    s0 = st_addr.size();
    issue(1'b1, 1'b0, 16'h01CE, 3'd4, 32'hAABBCCDD, t);
    settle(12);
    n_checks++; if (st_addr.size() - s0 !== 2) begin n_fail++; $display("FAIL half_write_strobes: got %0d want 2", st_addr.size() - s0); end
    else begin
      n_checks++; if (st_addr[s0] !== 16'h01CE || st_wdata[s0][15:0] !== 16'hCCDD || st_size[s0] !== 3'd4) begin
        n_fail++; $display("FAIL half_write_first: got %h/%h/%0d want 01CE/CCDD/4", st_addr[s0], st_wdata[s0][15:0], st_size[s0]); end
      n_checks++; if (st_addr[s0+1] !== 16'h01D0 || st_wdata[s0+1][15:0] !== 16'hAABB || st_size[s0+1] !== 3'd2) begin
        n_fail++; $display("FAIL half_write_second: got %h/%h/%0d want 01D0/AABB/2", st_addr[s0+1], st_wdata[s0+1][15:0], st_size[s0+1]); end
      n_checks++; if (st_cyc[s0+1] - st_cyc[s0] !== 3) begin n_fail++; $display("FAIL half_write_spacing: got %0d want 3", st_cyc[s0+1] - st_cyc[s0]); end
    end
    n_checks++; if (wr_done_last - t !== 6) begin n_fail++; $display("FAIL half_write_done_cyc: got T+%0d want T+6", wr_done_last - t); end
  endtask

  task automatic test_simultaneous;
    int t, s0, rd0, wr0;
    bus_width = 2'd2;
    s0 = st_addr.size(); rd0 = rd_done_cnt; wr0 = wr_done_cnt;
    issue(1'b1, 1'b1, 16'h0060, 3'd2, 32'h12345678, t);
    settle(12);
    n_checks++; if (st_addr.size() - s0 !== 1) begin n_fail++; $display("FAIL simul_strobes: got %0d want 1", st_addr.size() - s0); end
    else begin
      n_checks++; if (st_wr[s0] !== 1'b1 || st_addr[s0] !== 16'h0060 || st_size[s0] !== 3'd2 || st_wdata[s0][15:0] !== 16'h5678) begin
        n_fail++; $display("FAIL simul_cycle: got wr %b %h %0d %h want 1 0060 2 5678", st_wr[s0], st_addr[s0], st_size[s0], st_wdata[s0][15:0]); end
    end
    n_checks++; if (wr_done_cnt - wr0 !== 1 || rd_done_cnt - rd0 !== 0) begin
      n_fail++; $display("FAIL simul_done: got wr %0d rd %0d want 1/0", wr_done_cnt - wr0, rd_done_cnt - rd0); end
    n_checks++; if (cpu_read_data !== 32'h44332211) begin n_fail++; $display("FAIL simul_rdata_kept: got %h want 44332211", cpu_read_data); end
  endtask

  task automatic test_wait_read;
    int t;
    bus_width = 2'd2;
    rd_table[0] = 32'h99887766;
    rd_base = rd_strobes;
    wait_until = cyc + 6;
    issue(1'b0, 1'b1, 16'h0071, 3'd1, 32'h0, t);
    settle(15);
    n_checks++; if (rd_done_last - t !== 7) begin n_fail++; $display("FAIL wait_read_done_cyc: got T+%0d want T+7", rd_done_last - t); end
    n_checks++; if (cpu_read_data !== 32'h44332266) begin n_fail++; $display("FAIL wait_read_data: got %h want 44332266", cpu_read_data); end
  endtask

  task automatic test_timeout;
    int t, s0, to0, rd0;
    bus_width = 2'd0;
    rd_base = rd_strobes; s0 = st_addr.size(); to0 = to_cnt; rd0 = rd_done_cnt;
    wait_all = 1'b1;
    issue(1'b0, 1'b1, 16'h02F8, 3'd2, 32'h0, t);
    settle(35);
    wait_all = 1'b0;
    n_checks++; if (to_cnt - to0 !== 2 || to_last - t !== 22) begin
      n_fail++; $display("FAIL timeout_pulses: got %0d last T+%0d want 2 last T+22", to_cnt - to0, to_last - t); end
    n_checks++; if (st_addr.size() - s0 !== 2) begin n_fail++; $display("FAIL timeout_strobes: got %0d want 2", st_addr.size() - s0); end
    else begin
      n_checks++; if (st_cyc[s0] - t !== 2 || st_cyc[s0+1] - t !== 13 || st_addr[s0+1] !== 16'h02F9) begin
        n_fail++; $display("FAIL timeout_strobe_timing: got T+%0d T+%0d %h want T+2 T+13 02F9", st_cyc[s0] - t, st_cyc[s0+1] - t, st_addr[s0+1]); end
    end
    n_checks++; if (cpu_read_data !== 32'h4433FFFF) begin n_fail++; $display("FAIL timeout_data: got %h want 4433FFFF", cpu_read_data); end
    n_checks++; if (rd_done_cnt - rd0 !== 1 || rd_done_last - t !== 22) begin
      n_fail++; $display("FAIL timeout_done: got %0d at T+%0d want 1 at T+22", rd_done_cnt - rd0, rd_done_last - t); end
  endtask

  task automatic test_reset_mid;
    int t, rd0;
    bus_width = 2'd0;
    rd0 = rd_done_cnt;
    wait_all = 1'b1;
    issue(1'b0, 1'b1, 16'h0010, 3'd2, 32'h0, t);
    settle(3);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_mid_busy_before: got %b want 1", busy); end
    reset = 1'b1;
    settle(1);
    reset = 1'b0;
    n_checks++; if (busy !== 1'b0 || bus_read !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_idle: got busy %b read %b want 0 0", busy, bus_read); end
    wait_all = 1'b0;
    settle(20);
    n_checks++; if (rd_done_cnt - rd0 !== 0) begin n_fail++; $display("FAIL reset_mid_no_done: got %0d want 0", rd_done_cnt - rd0); end
  endtask

  task automatic test_back_to_back;
    int t, s0;
    bus_width = 2'd0;
    rd_table[0] = 32'h0000005A; rd_table[1] = 32'h000000A5;
    rd_base = rd_strobes; s0 = st_addr.size();
    issue(1'b0, 1'b1, 16'hFFFF, 3'd2, 32'h0, t);
    settle(15);
    n_checks++; if (st_addr.size() - s0 !== 2) begin n_fail++; $display("FAIL wrap_strobes: got %0d want 2", st_addr.size() - s0); end
    else begin
      n_checks++; if (st_addr[s0] !== 16'hFFFF || st_addr[s0+1] !== 16'h0000) begin
        n_fail++; $display("FAIL wrap_addr: got %h %h want FFFF 0000", st_addr[s0], st_addr[s0+1]); end
    end
    n_checks++; if (cpu_read_data !== 32'h0000A55A || rd_done_last - t !== 8) begin
      n_fail++; $display("FAIL wrap_data: got %h at T+%0d want 0000A55A at T+8", cpu_read_data, rd_done_last - t); end
  endtask

  task automatic test_len_edge;
    int t, s0;
    s0 = st_addr.size();
    issue(1'b0, 1'b1, 16'h0010, 3'd0, 32'h0, t);
    settle(6);
    n_checks++; if (st_addr.size() - s0 !== 0 || rd_done_last - t !== 1 || cpu_read_data !== 32'h0000A55A) begin
      n_fail++; $display("FAIL len0: got %0d strobes done T+%0d data %h want 0 T+1 0000A55A", st_addr.size() - s0, rd_done_last - t, cpu_read_data); end
    bus_width = 2'd2;
    s0 = st_addr.size();
    issue(1'b1, 1'b0, 16'h0020, 3'd7, 32'h01020304, t);
    settle(8);
    n_checks++; if (st_addr.size() - s0 !== 1) begin n_fail++; $display("FAIL clamp_strobes: got %0d want 1", st_addr.size() - s0); end
    else begin
      n_checks++; if (st_size[s0] !== 3'd4) begin n_fail++; $display("FAIL clamp_size: got %0d want 4", st_size[s0]); end
    end
  endtask

  initial begin
    reset = 1'b1;
    cpu_read_do = 1'b0; cpu_read_address = '0; cpu_read_length = '0;
    cpu_write_do = 1'b0; cpu_write_address = '0; cpu_write_length = '0; cpu_write_data = '0;
    bus_width = 2'd0;
    for (int i = 0; i < 8; i++) rd_table[i] = 32'h0;
    test_reset;
    test_byte_read;
    test_word_write;
    test_half_write;
    test_simultaneous;
    test_wait_read;
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    test_len_edge;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
